// File: rtl/dmem_pkg.sv
// Shared sizing and port constants for the data-memory arbiter and its round-robin core.
package dmem_pkg;

  localparam int WIDTH          = 32;
  localparam int MEM_WIDTH      = 8;
  localparam int MEM_DEPTH      = 1024;
  localparam int LAST_WORD_ADDR = MEM_DEPTH - 4;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  typedef enum logic {
    PTR_PORT0 = 1'b0,
    PTR_PORT1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic: combinational grant, pointer flips to the other port after each grant.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt[PORT0] = 1'b1;
        2'b10:   gnt[PORT1] = 1'b1;
        2'b11: begin
          if (ptr_q == PTR_PORT0) gnt[PORT0] = 1'b1;
          else                    gnt[PORT1] = 1'b1;
        end
        default: gnt = 2'b00;
      endcase
    end

    ptr_d = ptr_q;
    if (gnt[PORT0])      ptr_d = PTR_PORT1;
    else if (gnt[PORT1]) ptr_d = PTR_PORT0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PTR_PORT0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two word-access requesters onto the byte-organised dmem and returns registered,
// range/alignment-checked responses one cycle after each grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int WIDTH     = dmem_pkg::WIDTH,
  parameter int MEM_WIDTH = dmem_pkg::MEM_WIDTH,
  parameter int MEM_DEPTH = dmem_pkg::MEM_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic [WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0] r0_wdata,
  output logic             r0_gnt,
  output logic             r0_rvalid,
  output logic [WIDTH-1:0] r0_rdata,
  output logic             r0_err,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic [WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r1_gnt,
  output logic             r1_rvalid,
  output logic [WIDTH-1:0] r1_rdata,
  output logic             r1_err,
  output logic             dmem_sel,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata
);

  localparam int WORD_BYTES = WIDTH / MEM_WIDTH;
  // Highest byte address at which a whole word still fits inside dmem.
  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(MEM_DEPTH - WORD_BYTES);

  logic [1:0]            req;
  logic [1:0]            we;
  logic [1:0]            gnt;
  logic [1:0][WIDTH-1:0] addr;
  logic [1:0][WIDTH-1:0] wdata;

  assign req   = {r1_req, r0_req};
  assign we    = {r1_we, r0_we};
  assign addr  = {r1_addr, r0_addr};
  assign wdata = {r1_wdata, r0_wdata};

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  logic             acc_valid;
  logic             acc_port;
  logic             acc_we;
  logic             acc_err;
  logic [WIDTH-1:0] acc_addr;
  logic [WIDTH-1:0] acc_wdata;

  always_comb begin
    acc_valid = |gnt;
    acc_port  = gnt[PORT1];
    acc_we    = we[acc_port];
    acc_addr  = addr[acc_port];
    acc_wdata = wdata[acc_port];
    acc_err   = acc_valid && ((acc_addr[1:0] != 2'b00) || (acc_addr > LAST_ADDR));

    // Error accesses still consume the grant but never reach dmem.
    dmem_sel   = acc_valid && acc_we && !acc_err;
    dmem_addr  = (acc_valid && !acc_err) ? acc_addr : '0;
    dmem_wdata = dmem_sel ? acc_wdata : '0;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic             rvalid_q;
    logic             rvalid_d;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
      rvalid_d = gnt[gi];
      err_d    = gnt[gi] && acc_err;
      rdata_d  = rdata_q;
      if (gnt[gi]) rdata_d = (acc_err || acc_we) ? '0 : dmem_rdata;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rvalid_d;
        err_q    <= err_d;
        rdata_q  <= rdata_d;
      end
    end
  end

  assign r0_gnt    = gnt[PORT0];
  assign r1_gnt    = gnt[PORT1];
  assign r0_rvalid = g_port[PORT0].rvalid_q;
  assign r0_err    = g_port[PORT0].err_q;
  assign r0_rdata  = g_port[PORT0].rdata_q;
  assign r1_rvalid = g_port[PORT1].rvalid_q;
  assign r1_err    = g_port[PORT1].err_q;
  assign r1_rdata  = g_port[PORT1].rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-port request queues, a byte-wide dmem model and a reference memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_req, r0_we, r0_gnt, r0_rvalid, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        dmem_sel;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .r0_req     (r0_req),
    .r0_we      (r0_we),
    .r0_addr    (r0_addr),
    .r0_wdata   (r0_wdata),
    .r0_gnt     (r0_gnt),
    .r0_rvalid  (r0_rvalid),
    .r0_rdata   (r0_rdata),
    .r0_err     (r0_err),
    .r1_req     (r1_req),
    .r1_we      (r1_we),
    .r1_addr    (r1_addr),
    .r1_wdata   (r1_wdata),
    .r1_gnt     (r1_gnt),
    .r1_rvalid  (r1_rvalid),
    .r1_rdata   (r1_rdata),
    .r1_err     (r1_err),
    .dmem_sel   (dmem_sel),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-organised dmem model: combinational little-endian read, write on the rising edge.
  logic [7:0] mem [1024];
  logic [9:0] da;
  assign da = dmem_addr[9:0];
  assign dmem_rdata = {mem[da + 10'd3], mem[da + 10'd2], mem[da + 10'd1], mem[da]};

  always @(posedge clk) begin
    if (dmem_sel) begin
      mem[da]         <= dmem_wdata[7:0];
      mem[da + 10'd1] <= dmem_wdata[15:8];
      mem[da + 10'd2] <= dmem_wdata[23:16];
      mem[da + 10'd3] <= dmem_wdata[31:24];
    end
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  op_t   q0[$];
  op_t   q1[$];
  resp_t exp_q[$];
  logic [7:0] ref_bytes [1024];
  int    ptr;
  int    checks;
  int    errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] i;
    i = a[9:0];
    return {ref_bytes[i + 10'd3], ref_bytes[i + 10'd2], ref_bytes[i + 10'd1], ref_bytes[i]};
  endfunction

  task automatic push_op(input int port, input logic we, input logic [31:0] a, input logic [31:0] d);
    op_t op;
    op.we = we; op.addr = a; op.wdata = d;
    if (port == 0) q0.push_back(op);
    else           q1.push_back(op);
  endtask

  // One clock cycle: drive queue heads, check the previous cycle's response and this cycle's grant.
  task automatic step(input logic do_rst);
    op_t   h0, h1, op;
    resp_t e;
    int    g;
    logic  bad;
    h0 = '0; h1 = '0;
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    rst      = do_rst;
    r0_req   = (q0.size() > 0);
    r0_we    = h0.we;
    r0_addr  = h0.addr;
    r0_wdata = h0.wdata;
    r1_req   = (q1.size() > 0);
    r1_we    = h1.we;
    r1_addr  = h1.addr;
    r1_wdata = h1.wdata;
    @(negedge clk);

    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.port == 1'b0) begin
        check("r0_rvalid", 32'(r0_rvalid), 32'd1);
        check("r1_rvalid_idle", 32'(r1_rvalid), 32'd0);
        check("r0_rdata", r0_rdata, e.rdata);
        check("r0_err", 32'(r0_err), 32'(e.err));
      end else begin
        check("r1_rvalid", 32'(r1_rvalid), 32'd1);
        check("r0_rvalid_idle", 32'(r0_rvalid), 32'd0);
        check("r1_rdata", r1_rdata, e.rdata);
        check("r1_err", 32'(r1_err), 32'(e.err));
      end
    end else begin
      check("r0_rvalid_none", 32'(r0_rvalid), 32'd0);
      check("r1_rvalid_none", 32'(r1_rvalid), 32'd0);
    end

    g = -1;
    if (!do_rst) begin
      if (r0_req && r1_req) g = ptr;
      else if (r0_req)      g = 0;
      else if (r1_req)      g = 1;
    end
    check("r0_gnt", 32'(r0_gnt), 32'(g == 0));
    check("r1_gnt", 32'(r1_gnt), 32'(g == 1));

    if (g >= 0) begin
      op  = (g == 0) ? h0 : h1;
      bad = (op.addr[1:0] != 2'b00) || (op.addr > 32'd1020);
      check("dmem_sel", 32'(dmem_sel), 32'(!bad && op.we));
      if (!bad) check("dmem_addr", dmem_addr, op.addr);
      if (!bad && op.we) check("dmem_wdata", dmem_wdata, op.wdata);
      e.port  = (g == 1);
      e.err   = bad;
      e.rdata = (bad || op.we) ? 32'd0 : ref_word(op.addr);
      if (!bad && op.we) begin
        for (int k = 0; k < 4; k++) ref_bytes[op.addr[9:0] + 10'(k)] = op.wdata[8*k +: 8];
      end
      exp_q.push_back(e);
      ptr = 1 - g;
      if (g == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      $display("txn t=%0t port%0d %s addr=%h wdata=%h exp_rdata=%h exp_err=%0d",
               $time, g, op.we ? "WR" : "RD", op.addr, op.wdata, e.rdata, e.err);
    end else begin
      check("dmem_sel_idle", 32'(dmem_sel), 32'd0);
      check("dmem_addr_idle", dmem_addr, 32'd0);
      check("dmem_wdata_idle", dmem_wdata, 32'd0);
    end

    if (do_rst) begin
      ptr = 0;
      q0.delete();
      q1.delete();
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
      step(1'b0);
      n++;
    end
    check("drain_bound", 32'(n < 200), 32'd1);
    step(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    ptr    = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]       <= 8'(i * 7 + 3);
      ref_bytes[i]  = 8'(i * 7 + 3);
    end
    rst = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    @(posedge clk);
    #1;

    // Reset state
    step(1'b1);
    step(1'b0);
    check("rst_r0_rdata", r0_rdata, 32'd0);
    check("rst_r1_rdata", r1_rdata, 32'd0);
    check("rst_r0_err", 32'(r0_err), 32'd0);
    check("rst_r1_err", 32'(r1_err), 32'd0);

    // Port 0 write then read back
    push_op(0, 1'b1, 32'h8, 32'hDEADBEEF);
    push_op(0, 1'b0, 32'h8, 32'h0);
    drain();

    // Both ports continuously requesting right after reset
    step(1'b1);
    for (int i = 0; i < 3; i++) begin
      push_op(0, 1'b0, 32'h0, 32'h0);
      push_op(1, 1'b1, 32'h4, 32'hAAAAAAAA);
    end
    drain();

    // Misaligned write must not disturb memory
    push_op(1, 1'b1, 32'h6, 32'hFFFFFFFF);
    push_op(1, 1'b0, 32'h4, 32'h0);
    drain();

    // Range boundary
    push_op(0, 1'b0, 32'h3FD, 32'h0);
    push_op(0, 1'b0, 32'h3FC, 32'h0);
    push_op(0, 1'b0, 32'h400, 32'h0);
    push_op(0, 1'b1, 32'h3FC, 32'h01020304);
    push_op(0, 1'b0, 32'h3FC, 32'h0);
    push_op(1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    drain();

    // Write-then-read in consecutive cycles
    push_op(0, 1'b1, 32'h8, 32'hDDDDAAAA);
    push_op(0, 1'b0, 32'h8, 32'h0);
    drain();

    // Reset collides with a port 0 write; pointer must return to port 0
    push_op(0, 1'b1, 32'hC, 32'h12345678);
    step(1'b1);
    step(1'b0);
    check("post_rst_r0_err", 32'(r0_err), 32'd0);
    check("post_rst_r1_err", 32'(r1_err), 32'd0);
    push_op(0, 1'b0, 32'hC, 32'h0);
    push_op(1, 1'b0, 32'h10, 32'h0);
    drain();

    // Mixed traffic
    for (int i = 0; i < 16; i++) begin
      push_op(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255) * 4 + (($urandom_range(0, 7) == 0) ? 1 : 0)), $urandom);
      push_op(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255) * 4), $urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
